// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : ser_pkg                                                    |
// | Description : Shared constants and state encoding for bit_serializer.   |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
`default_nettype none

package ser_pkg;

   // Defaults shared with the run-length detector testbenches
   localparam int   DEF_WIDTH    = 8;
   localparam logic DEF_IDLE_LVL = 1'b0;

   // Serializer FSM encoding; PARITY is reachable only with SER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_t;

endpackage : ser_pkg

`default_nettype wire

// File: rtl/ser_bit_cnt.sv
// ---------------------------------------------------------------------------
// | Module      : ser_bit_cnt                                                |
// | Description : Loadable down-counter tracking the bits left in a word.   |
// |               Loads WIDTH-1, decrements to 0 and holds; zero_o flags    |
// |               that the LSB is the bit currently on the line.            |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
`default_nettype none

module ser_bit_cnt #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          zero_o
);

   localparam logic [CW-1:0] C_CNT_MAX = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q;

   // Load takes priority over decrement; the count saturates at zero
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= C_CNT_MAX;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule : ser_bit_cnt

`default_nettype wire

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// | Module      : bit_serializer                                             |
// | Description : Parallel-to-serial front end. Accepts a WIDTH-bit word on |
// |               load && ready and shifts it out MSB-first on sout, one bit|
// |               per clock, with sout_valid and a last-bit done pulse.     |
// |               Define SER_PARITY_EN to append an even-parity bit.        |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
`default_nettype none

module bit_serializer
   import ser_pkg::*;
#(
   parameter int   WIDTH    = DEF_WIDTH,
   parameter logic IDLE_LVL = DEF_IDLE_LVL
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0]    cnt;
   logic             accept;

`ifdef SER_PARITY_EN
   logic             par_q, par_d;
   logic             unused_cnt;
   assign unused_cnt = ^cnt;
`endif

   ser_bit_cnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_cnt (
      .clk_i  (clk),
      .rst_i  (RESET),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .cnt_o  (cnt),
      .zero_o (cnt_zero)
   );

   // ready is open in IDLE and in the final cycle of a word, never in reset
   always_comb begin
`ifdef SER_PARITY_EN
      ready = !RESET && ((state_q == IDLE) || (state_q == PARITY));
`else
      ready = !RESET && ((state_q == IDLE) || ((state_q == SHIFT) && cnt_zero));
`endif
   end

   assign accept = load && ready;

   // Next-state, shift-register and registered-output decode
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      sout_d   = IDLE_LVL;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
`ifdef SER_PARITY_EN
      par_d    = par_q;
`endif

      // Word accept: MSB goes straight to the output register, the rest
      // waits in the shift register already aligned to its top bit
      if (accept) begin
         state_d  = SHIFT;
         shreg_d  = din << 1;
         sout_d   = din[WIDTH-1];
         valid_d  = 1'b1;
         cnt_load = 1'b1;
`ifdef SER_PARITY_EN
         par_d    = ^din;
`endif
      end else begin
         case (state_q)
            SHIFT: begin
               if (!cnt_zero) begin
                  sout_d  = shreg_q[WIDTH-1];
                  shreg_d = shreg_q << 1;
                  valid_d = 1'b1;
                  cnt_dec = 1'b1;
`ifndef SER_PARITY_EN
                  done_d  = (cnt == CW'(1));
`endif
               end else begin
`ifdef SER_PARITY_EN
                  state_d = PARITY;
                  sout_d  = par_q;
                  valid_d = 1'b1;
                  done_d  = 1'b1;
`else
                  state_d = IDLE;
`endif
               end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
               state_d = IDLE;
            end
`endif
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset discards any partial word
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q <= IDLE;
         shreg_q <= '0;
         sout_q  <= IDLE_LVL;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         done_q  <= done_d;
`ifdef SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign sout       = sout_q;
   assign sout_valid = valid_q;
   assign done       = done_q;

endmodule : bit_serializer

`default_nettype wire

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// | Module      : tb_bit_serializer                                          |
// | Description : Directed self-checking bench for bit_serializer (WIDTH=8).|
// |               Honours SER_PARITY_EN for the word length and parity bit. |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int N = 9;
`else
   localparam int N = 8;
`endif

   logic       clk = 1'b0;
   logic       RESET;
   logic       load;
   logic [7:0] din;
   logic       ready;
   logic       sout;
   logic       sout_valid;
   logic       done;

   int checks   = 0;
   int failures = 0;

   bit_serializer #(
      .WIDTH    (8),
      .IDLE_LVL (1'b0)
   ) dut (
      .clk        (clk),
      .RESET      (RESET),
      .load       (load),
      .din        (din),
      .ready      (ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .done       (done)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Bit k of the serial frame for word w: MSB first, then the parity bit
   function automatic logic exp_bit(input logic [7:0] w, input int k);
      logic [7:0] t;
      t = w;
      if (k < 8) return t[7-k];
      return ^t;
   endfunction

   task automatic test_reset();
      logic [3:0] e;
      RESET = 1'b1; load = 1'b1; din = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         e = 4'b0000;
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL reset c%0d: sout/valid/done/ready=%b required %b", c, {sout, sout_valid, done, ready}, e);
         end
      end
      RESET = 1'b0; load = 1'b0;
      #1;
      e = 4'b0001;
      checks++;
      if ({sout, sout_valid, done, ready} !== e) begin
         failures++;
         $display("FAIL reset_release: sout/valid/done/ready=%b required %b", {sout, sout_valid, done, ready}, e);
      end
   endtask

   task automatic test_idle();
      logic [3:0] e;
      e = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL idle c%0d: sout/valid/done/ready=%b required %b", c, {sout, sout_valid, done, ready}, e);
         end
      end
   endtask

   task automatic test_single(input logic [7:0] w);
      logic [3:0] e;
      @(negedge clk); load = 1'b1; din = w;
      @(negedge clk); load = 1'b0;
      for (int k = 0; k < N; k++) begin
         e = {exp_bit(w, k), 1'b1, (k == N-1), (k == N-1)};
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL single %h bit%0d: sout/valid/done/ready=%b required %b", w, k, {sout, sout_valid, done, ready}, e);
         end
         @(negedge clk);
      end
      e = 4'b0001;
      checks++;
      if ({sout, sout_valid, done, ready} !== e) begin
         failures++;
         $display("FAIL single %h after: sout/valid/done/ready=%b required %b", w, {sout, sout_valid, done, ready}, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] e;
      @(negedge clk); load = 1'b1; din = 8'hFF;
      @(negedge clk);
      for (int k = 0; k < 2*N; k++) begin
         if (k < N) e = {exp_bit(8'hFF, k), 1'b1, (k == N-1), (k == N-1)};
         else       e = {exp_bit(8'h00, k-N), 1'b1, (k == 2*N-1), (k == 2*N-1)};
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL b2b bit%0d: sout/valid/done/ready=%b required %b", k, {sout, sout_valid, done, ready}, e);
         end
         if (k == N-1) din = 8'h00;
         if (k == N)   load = 1'b0;
         @(negedge clk);
      end
      e = 4'b0001;
      checks++;
      if ({sout, sout_valid, done, ready} !== e) begin
         failures++;
         $display("FAIL b2b after: sout/valid/done/ready=%b required %b", {sout, sout_valid, done, ready}, e);
      end
   endtask

   task automatic test_busy_load();
      logic [3:0] e;
      @(negedge clk); load = 1'b1; din = 8'hA5;
      @(negedge clk); load = 1'b0;
      for (int k = 0; k < N; k++) begin
         e = {exp_bit(8'hA5, k), 1'b1, (k == N-1), (k == N-1)};
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL busy bit%0d: sout/valid/done/ready=%b required %b", k, {sout, sout_valid, done, ready}, e);
         end
         if (k == 3) begin load = 1'b1; din = 8'h3C; end
         if (k == 4) load = 1'b0;
         @(negedge clk);
      end
      for (int c = 0; c < 3; c++) begin
         e = 4'b0001;
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL busy after c%0d: sout/valid/done/ready=%b required %b", c, {sout, sout_valid, done, ready}, e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] e;
      @(negedge clk); load = 1'b1; din = 8'hA5;
      @(negedge clk); load = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         e = {exp_bit(8'hA5, k), 1'b1, 1'b0, 1'b0};
         checks++;
         if ({sout, sout_valid, done, ready} !== e) begin
            failures++;
            $display("FAIL rstmid bit%0d: sout/valid/done/ready=%b required %b", k, {sout, sout_valid, done, ready}, e);
         end
         if (k < 4) @(negedge clk);
      end
      RESET = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid ready_in_reset: ready=%b required 0", ready);
      end
      @(negedge clk);
      e = 4'b0000;
      checks++;
      if ({sout, sout_valid, done, ready} !== e) begin
         failures++;
         $display("FAIL rstmid flushed: sout/valid/done/ready=%b required %b", {sout, sout_valid, done, ready}, e);
      end
      @(negedge clk);
      RESET = 1'b0;
      #1;
      e = 4'b0001;
      checks++;
      if ({sout, sout_valid, done, ready} !== e) begin
         failures++;
         $display("FAIL rstmid release: sout/valid/done/ready=%b required %b", {sout, sout_valid, done, ready}, e);
      end
      test_single(8'h81);
   endtask

`ifdef SER_PARITY_EN
   task automatic test_parity();
      test_single(8'h07);
      test_single(8'h03);
   endtask
`endif

   initial begin
      RESET = 1'b1;
      load  = 1'b0;
      din   = 8'h00;
      test_reset();
      test_idle();
      test_single(8'hA5);
      test_back_to_back();
      test_busy_load();
      test_reset_mid();
`ifdef SER_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bit_serializer

`default_nettype wire
